mem_interface_pipelined: RTL and testbench
==========================================

Name: mem_interface_pipelined

Overview:
- Parametrised successor to the single-cycle core memory interface.
- Owns a word-addressed data array and accepts read/write requests under a valid/ready handshake.
- Adds configurable memory latency, up to DEPTH outstanding requests, and a back-pressurable response queue.
- Sits between a core's load/store unit (or cache miss path) and on-chip memory; responses return in request order.

Parameters:
- CORE, 0, core ID printed in report output
- DATA_WIDTH, 32, data word width in bits
- ADDRESS_BITS, 12, word address width; array holds 2^ADDRESS_BITS words
- LATENCY, 2, cycles from request accept to response valid; legal range 1..8
- DEPTH, 4, maximum outstanding requests and response-queue capacity; power of two, 2..16

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- read  in  1  read request, qualified by ready
- write  in  1  write request, qualified by ready
- address  in  ADDRESS_BITS  request word address
- in_data  in  DATA_WIDTH  write data
- ready  out  1  interface can accept a request this cycle
- valid  out  1  response at head of queue
- resp_ready  in  1  consumer pops the head response this cycle
- out_addr  out  ADDRESS_BITS  address of head response
- out_data  out  DATA_WIDTH  read data for a read response; 0 for a write ack
- out_is_write  out  1  head response is a write ack
- err  out  1  sticky: read and write were both asserted in an accepted cycle
- report  in  1  print a state/counter dump each cycle while high

Behaviour:
- Clock and reset: one clock. reset is synchronous and active-high.
- Accept: a request is accepted when (read|write) & ready at a rising edge.
- ready = !reset & (outstanding < DEPTH).
- Outstanding counter:
  - +1 on accept, -1 on pop (valid & resp_ready); both in the same cycle leaves it unchanged.
  - Width is clog2(DEPTH)+1; it never exceeds DEPTH, so the response queue cannot overflow.
- Write: the array is updated at the accept edge. A write ack enters the pipeline with out_data=0 and out_is_write=1.
- Read:
  - The array is read at the accept edge; the result carries through LATENCY-1 further register stages.
  - A read accepted the cycle after a write to the same address returns the new data.
  - A read accepted in the same cycle as nothing else returns the old data.
- Simultaneous read & write on an accepted cycle: treated as a write, and err is set. err clears only on reset.
- Latency: a request accepted in cycle t, with an empty queue, gives valid=1 in cycle t+LATENCY. Responses with no back-pressure sustain one per cycle.
- Response queue:
  - In-order FIFO of DEPTH entries; the head drives out_addr, out_data and out_is_write.
  - Pipeline exit and pop in the same cycle are both honoured.
- Idle outputs: when valid=0, out_addr, out_data and out_is_write are 0.
- Reset, including mid-operation:
  - Pipeline valid bits, queue pointers, outstanding, err and counters are cleared.
  - In-flight requests are dropped.
  - Array contents are not cleared.
  - Outputs during and after reset: valid=0, ready=0 during the reset cycle, ready=1 the cycle after.
- Counters: 32-bit cycles, reads_accepted and writes_accepted. All wrap modulo 2^32 and are cleared on reset.
- report: $display of CORE, cycles, counters, ready, valid, outstanding and head response fields.

Decomposition:
- Shared package memif_pkg holds:
  - the response struct (addr, data, is_write);
  - MEMIF_MAX_LATENCY=8;
  - the clog2 helper function.
- One sub-module, mem_resp_fifo: a parametrised synchronous FIFO of response structs with push/pop, full/empty and count. It is instantiated once for the response queue.
- The latency pipeline and the array stay in the top module.

Test Plan:
- Write 0xDEADBEEF to address 0x010, then read 0x010 the next cycle, LATENCY=2, resp_ready=1 -> write ack valid at t+2 (out_is_write=1, out_data=0); read response valid at t+3 with out_data=0xDEADBEEF, out_addr=0x010.
- resp_ready=0, issue 6 reads back-to-back, DEPTH=4 -> ready drops after the 4th accept; 4 responses queued in order. Raising resp_ready drains them one per cycle, and ready returns the cycle after the first pop.
- Streaming reads to addresses 0..15 with resp_ready=1 -> ready stays 1, valid stays high from cycle LATENCY onward, and out_addr increments 0..15 with no bubbles.
- read=1 and write=1 together to address 0x020 with data 0x5 -> treated as a write; err=1 and stays high; a later read of 0x020 returns 0x5.
- Assert reset with 3 requests in flight -> next cycle valid=0, outstanding=0, err=0; a read of a previously written address still returns the old data.
- LATENCY=1 regression: accept in cycle t -> valid in cycle t+1; simultaneous accept and pop sustains full throughput with outstanding=1.

Source files
------------

// File: rtl/memif_pkg.sv
// Shared types and helpers for the pipelined memory interface.
package memif_pkg;

  localparam int unsigned MEMIF_MAX_LATENCY     = 8;
  localparam int unsigned MEMIF_DEF_DATA_WIDTH  = 32;
  localparam int unsigned MEMIF_DEF_ADDR_BITS   = 12;

  // Response record at default widths; the top re-declares it at its own widths.
  typedef struct packed {
    logic [MEMIF_DEF_ADDR_BITS-1:0]  addr;
    logic [MEMIF_DEF_DATA_WIDTH-1:0] data;
    logic                            is_write;
  } mem_resp_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Synchronous in-order FIFO of response records with fall-through head.
module mem_resp_fifo
  import memif_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = mem_resp_t
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 push_i,
  input  entry_t               data_i,
  input  logic                 pop_i,
  output entry_t               data_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [clog2(DEPTH):0] count_o
);

  localparam int unsigned PtrW = clog2(DEPTH);

  entry_t            mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic              push_en, pop_en;

  // Qualify push/pop against occupancy; both may fire in one cycle.
  always_comb begin
    push_en = push_i && !full_o;
    pop_en  = pop_i && !empty_o;
    count_d = count_q + (PtrW + 1)'(push_en) - (PtrW + 1)'(pop_en);
  end

  // Storage has no reset; only pointers define which entries are live.
  always_ff @(posedge clock_i) begin
    if (push_en) mem_q[wptr_q] <= data_i;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Head and status outputs.
  always_comb begin
    data_o  = mem_q[rptr_q];
    full_o  = (count_q == (PtrW + 1)'(DEPTH));
    empty_o = (count_q == '0);
    count_o = count_q;
  end

endmodule

// File: rtl/mem_interface_pipelined.sv
// Word-addressed memory with valid/ready requests, fixed latency and an in-order response queue.
module mem_interface_pipelined
  import memif_pkg::*;
#(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 12,
  parameter int unsigned LATENCY      = 2,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    read_i,
  input  logic                    write_i,
  input  logic [ADDRESS_BITS-1:0] address_i,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  output logic                    ready_o,
  output logic                    valid_o,
  input  logic                    resp_ready_i,
  output logic [ADDRESS_BITS-1:0] out_addr_o,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic                    out_is_write_o,
  output logic                    err_o,
  input  logic                    report_i
);

  localparam int unsigned CntW = clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDRESS_BITS-1:0] addr;
    logic [DATA_WIDTH-1:0]   data;
    logic                    is_write;
  } resp_t;

  logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_BITS];

  logic            accept, pop, is_wr;
  resp_t           entry, exit_entry, head;
  logic            exit_valid;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic            err_q, err_d;
  logic [31:0]     cycles_q, reads_q, writes_q;

  // Handshake and the response record formed at the accept edge.
  // A combined read+write is a write; the array read sees pre-edge contents.
  always_comb begin
    ready_o        = !reset_i && (outstanding_q < CntW'(DEPTH));
    accept         = (read_i || write_i) && ready_o;
    is_wr          = write_i;
    entry.addr     = address_i;
    entry.data     = is_wr ? '0 : mem_q[address_i];
    entry.is_write = is_wr;
    pop            = valid_o && resp_ready_i;
    outstanding_d  = outstanding_q + CntW'(accept) - CntW'(pop);
    err_d          = err_q || (accept && read_i && write_i);
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (accept && write_i) mem_q[address_i] <= in_data_i;
  end

  // LATENCY-1 register stages; the FIFO push register supplies the last cycle.
  if (LATENCY == 1) begin : g_no_pipe
    assign exit_valid = accept;
    assign exit_entry = entry;
  end else begin : g_pipe
    logic [LATENCY-2:0] vld_q;
    resp_t              ent_q [LATENCY-1];

    // Shift request records toward the response queue; reset drops in-flight ones.
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= accept;
        ent_q[0] <= entry;
        for (int i = 1; i < int'(LATENCY) - 1; i++) begin
          vld_q[i] <= vld_q[i-1];
          ent_q[i] <= ent_q[i-1];
        end
      end
    end

    assign exit_valid = vld_q[LATENCY-2];
    assign exit_entry = ent_q[LATENCY-2];
  end

  // Outstanding count bounds the queue, so a push is never refused.
  mem_resp_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (resp_t)
  ) u_resp_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .push_i  (exit_valid),
    .data_i  (exit_entry),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head drives outputs only while valid; reset masks the queue immediately.
  always_comb begin
    valid_o        = !fifo_empty && !reset_i;
    out_addr_o     = valid_o ? head.addr : '0;
    out_data_o     = valid_o ? head.data : '0;
    out_is_write_o = valid_o && head.is_write;
    err_o          = err_q;
  end

  // Outstanding, sticky error and activity counters.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
      cycles_q      <= '0;
      reads_q       <= '0;
      writes_q      <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      cycles_q      <= cycles_q + 32'd1;
      if (accept && read_i && !write_i) reads_q  <= reads_q + 32'd1;
      if (accept && write_i)            writes_q <= writes_q + 32'd1;
    end
  end

  // Per-cycle state dump while report is held high.
  always_ff @(posedge clock_i) begin
    if (report_i) begin
      $display("memif core %0d cyc %0d rd %0d wr %0d ready %0b valid %0b outst %0d q %0d/%0b head a=%0h d=%0h w=%0b",
               CORE, cycles_q, reads_q, writes_q, ready_o, valid_o, outstanding_q, fifo_count,
               fifo_full, out_addr_o, out_data_o, out_is_write_o);
    end
  end

endmodule

// File: tb/tb_mem_interface_pipelined.sv
// Directed bench: table-driven vectors plus hand sequences for back-pressure, streaming, reset and LATENCY=1.
module tb_mem_interface_pipelined;

  logic        clock = 1'b0;
  logic        rst;
  // LATENCY=2 instance
  logic        rd, wr, rr;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic        ready, valid, is_w, err;
  logic [11:0] oaddr;
  logic [31:0] odata;
  // LATENCY=1 instance
  logic        l1_rd, l1_wr, l1_rr;
  logic [11:0] l1_addr;
  logic [31:0] l1_wdata;
  logic        l1_ready, l1_valid, l1_is_w, l1_err;
  logic [11:0] l1_oaddr;
  logic [31:0] l1_odata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_interface_pipelined #(.LATENCY(2), .DEPTH(4)) dut (
    .clock_i(clock), .reset_i(rst), .read_i(rd), .write_i(wr), .address_i(addr),
    .in_data_i(wdata), .ready_o(ready), .valid_o(valid), .resp_ready_i(rr),
    .out_addr_o(oaddr), .out_data_o(odata), .out_is_write_o(is_w), .err_o(err),
    .report_i(1'b0)
  );

  mem_interface_pipelined #(.CORE(1), .LATENCY(1), .DEPTH(4)) dut1 (
    .clock_i(clock), .reset_i(rst), .read_i(l1_rd), .write_i(l1_wr), .address_i(l1_addr),
    .in_data_i(l1_wdata), .ready_o(l1_ready), .valid_o(l1_valid), .resp_ready_i(l1_rr),
    .out_addr_o(l1_oaddr), .out_data_o(l1_odata), .out_is_write_o(l1_is_w), .err_o(l1_err),
    .report_i(1'b0)
  );

  typedef struct {
    logic        rd, wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_ready, exp_valid;
    logic [11:0] exp_addr;
    logic [31:0] exp_data;
    logic        exp_isw, exp_err;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(logic r, logic w, logic [11:0] a, logic [31:0] d, logic ery,
                              logic ev, logic [11:0] ea, logic [31:0] ed, logic ew, logic ee);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d;
    v.exp_ready = ery; v.exp_valid = ev; v.exp_addr = ea; v.exp_data = ed;
    v.exp_isw = ew; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Head response of the LATENCY=2 instance; idle outputs must be zero.
  task automatic chk_resp(string name, logic ev, logic [11:0] ea, logic [31:0] ed, logic ew);
    chk({name, ".valid"}, 32'(valid), 32'(ev));
    chk({name, ".addr"},  32'(oaddr), ev ? 32'(ea) : 32'd0);
    chk({name, ".data"},  odata,      ev ? ed : 32'd0);
    chk({name, ".is_w"},  32'(is_w),  ev ? 32'(ew) : 32'd0);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
  endtask

  initial begin
    rst = 1'b1; rr = 1'b1; idle();
    l1_rd = 1'b0; l1_wr = 1'b0; l1_addr = '0; l1_wdata = '0; l1_rr = 1'b1;

    vecs[0] = mk(0, 1, 12'h010, 32'hDEADBEEF, 1, 0, 12'h000, 32'h0, 0, 0);
    vecs[1] = mk(1, 0, 12'h010, 32'h0,        1, 0, 12'h000, 32'h0, 0, 0);
    vecs[2] = mk(0, 0, 12'h000, 32'h0,        1, 1, 12'h010, 32'h0, 1, 0);
    vecs[3] = mk(0, 0, 12'h000, 32'h0,        1, 1, 12'h010, 32'hDEADBEEF, 0, 0);
    vecs[4] = mk(0, 0, 12'h000, 32'h0,        1, 0, 12'h000, 32'h0, 0, 0);
    vecs[5] = mk(1, 1, 12'h020, 32'h5,        1, 0, 12'h000, 32'h0, 0, 0);
    vecs[6] = mk(1, 0, 12'h020, 32'h0,        1, 0, 12'h000, 32'h0, 0, 1);
    vecs[7] = mk(0, 0, 12'h000, 32'h0,        1, 1, 12'h020, 32'h0, 1, 1);
    vecs[8] = mk(0, 0, 12'h000, 32'h0,        1, 1, 12'h020, 32'h5, 0, 1);
    vecs[9] = mk(0, 0, 12'h000, 32'h0,        1, 0, 12'h000, 32'h0, 0, 1);

    // Reset state
    tick(); #1;
    chk("rst.ready", 32'(ready), 32'd0);
    chk("rst.valid", 32'(valid), 32'd0);
    chk("rst.l1_ready", 32'(l1_ready), 32'd0);
    tick();
    rst = 1'b0; #1;
    chk("post_rst.ready", 32'(ready), 32'd1);
    chk("post_rst.err", 32'(err), 32'd0);
    chk_resp("post_rst", 0, '0, '0, 0);
    tick();

    // Write/read-after-write and combined read+write vectors
    for (int i = 0; i < 10; i++) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      chk($sformatf("vec%0d.ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d.err", i), 32'(err), 32'(vecs[i].exp_err));
      chk_resp($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_addr,
               vecs[i].exp_data, vecs[i].exp_isw);
      tick();
    end

    // Preload 0x100..0x103 for the back-pressure sequence
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; addr = 12'h100 + 12'(i); wdata = 32'hA0 + 32'(i);
      tick();
    end
    idle();
    tick(); tick(); tick();

    // Back-pressure: six back-to-back reads, only four fit
    begin
      int acc;
      acc = 0;
      rr = 1'b0;
      for (int c = 0; c < 6; c++) begin
        rd = 1'b1; addr = 12'h100 + 12'(acc);
        #1;
        chk($sformatf("bp%0d.ready", c), 32'(ready), (c < 4) ? 32'd1 : 32'd0);
        if (c < 4) acc++;
        tick();
      end
      idle();
      tick();
      #1;
      chk_resp("bp.head", 1, 12'h100, 32'hA0, 0);
      tick();
      rr = 1'b1;
      for (int p = 0; p < 5; p++) begin
        #1;
        chk($sformatf("drain%0d.ready", p), 32'(ready), (p == 0) ? 32'd0 : 32'd1);
        if (p < 4) chk_resp($sformatf("drain%0d", p), 1, 12'h100 + 12'(p), 32'hA0 + 32'(p), 0);
        else       chk_resp("drain_end", 0, '0, '0, 0);
        tick();
      end
    end

    // Streaming reads 0..15: no bubbles once the pipe fills
    for (int c = 0; c < 18; c++) begin
      rd = (c < 16); addr = 12'(c);
      #1;
      chk($sformatf("str%0d.ready", c), 32'(ready), 32'd1);
      chk($sformatf("str%0d.valid", c), 32'(valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk($sformatf("str%0d.addr", c), 32'(oaddr), 32'(c - 2));
      tick();
    end
    idle();
    tick();

    // Reset with three requests in flight
    rr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; addr = 12'h100 + 12'(i);
      tick();
    end
    idle();
    rst = 1'b1; #1;
    chk("midrst.ready", 32'(ready), 32'd0);
    chk("midrst.valid", 32'(valid), 32'd0);
    tick();
    rst = 1'b0; rr = 1'b1; rd = 1'b1; addr = 12'h010; #1;
    chk("after_rst.ready", 32'(ready), 32'd1);
    chk("after_rst.err", 32'(err), 32'd0);
    chk_resp("after_rst", 0, '0, '0, 0);
    tick();
    idle(); #1;
    chk_resp("after_rst+1", 0, '0, '0, 0);
    tick(); #1;
    chk_resp("after_rst.read", 1, 12'h010, 32'hDEADBEEF, 0);
    tick(); #1;
    chk_resp("after_rst.drained", 0, '0, '0, 0);
    tick();

    // LATENCY=1: write then six reads, one response per cycle
    for (int c = 0; c < 9; c++) begin
      l1_wr = (c == 0); l1_rd = (c >= 1 && c <= 6);
      l1_addr = 12'h030; l1_wdata = (c == 0) ? 32'h77 : 32'h0;
      #1;
      chk($sformatf("l1_%0d.ready", c), 32'(l1_ready), 32'd1);
      chk($sformatf("l1_%0d.valid", c), 32'(l1_valid), (c >= 1 && c <= 7) ? 32'd1 : 32'd0);
      if (c >= 1 && c <= 7) begin
        chk($sformatf("l1_%0d.is_w", c), 32'(l1_is_w), (c == 1) ? 32'd1 : 32'd0);
        chk($sformatf("l1_%0d.data", c), l1_odata, (c == 1) ? 32'd0 : 32'h77);
        chk($sformatf("l1_%0d.addr", c), 32'(l1_oaddr), 32'h030);
      end
      tick();
    end
    l1_rd = 1'b0; l1_wr = 1'b0;
    chk("l1.err", 32'(l1_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
